matmul_seq: RTL and testbench
=============================

# matmul_seq

Address and control sequencer for the complex DIM×DIM matrix-multiply datapath (C = A·B). It walks row i, column h and inner index j, and issues interleaved real/imag read addresses for A and B to the two dual-port coefficient memories. It also drives the MAC enable and accumulator clear, and flags each finished dot product when the result emerges from the accumulator pipeline. It replaces the hand-driven address loops used at bench level and sits between the memories and the accumulator block in the top level.

## Interface
- NBIT, 32, datapath word width (for documentation and width checks only; not used in the address path)
- DIM, 32, matrix dimension
- ADDRESS, $clog2(2*DIM*DIM), memory address width
- DIV, 16, clocks per issue slot; DIV ≥ 1
- LAT, 3, clocks from an issued product to a valid accumulator output; LAT ≥ 1

- clk_seq  in  1  system clock
- rst_seq  in  1  asynchronous, active-low reset
- start_seq  in  1  start one full C computation; sampled in IDLE only
- stall_seq  in  1  freezes issue while high
- addr_ar_seq  out  ADDRESS  A real-part address
- addr_ai_seq  out  ADDRESS  A imag-part address
- addr_br_seq  out  ADDRESS  B real-part address
- addr_bi_seq  out  ADDRESS  B imag-part address
- ena_seq  out  1  MAC enable, one-clock pulse per issued product
- clr_seq  out  1  accumulator clear, asserted together with ena_seq when j == 0
- flag_seq  out  1  one-clock pulse: the accumulator holds C[row_seq][col_seq]
- row_seq  out  $clog2(DIM)  row index of the flagged result
- col_seq  out  $clog2(DIM)  column index of the flagged result
- busy_seq  out  1  high from start acceptance through the final flag
- done_seq  out  1  one-clock pulse after the final flag

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start_seq. Counters i, h, j and the prescaler are cleared.
- RUN:
  - The prescaler counts 0..DIV-1. An issue slot occurs at count DIV-1 when stall_seq is low.
  - While stall_seq is high, the prescaler holds its value.
  - On each issue slot, the addresses are registered and ena_seq pulses.
  - Counter order: j is innermost, then h, then i. Each counter wraps at DIM-1.
- Address generation:
  - addr_ar = 2·j + 2·DIM·i; addr_ai = addr_ar + 1.
  - Without the macro, k = h·DIM + j. addr_br = 2·k; addr_bi = addr_br + 1.
- Result flagging:
  - An issue with j == DIM-1 pushes {i, h} into a LAT-deep delay line.
  - On exit from the delay line, flag_seq pulses and row_seq/col_seq carry the pushed indices.
- RUN → DRAIN after the issue at (DIM-1, DIM-1, DIM-1).
- DRAIN → DONE when the delay line is empty. DONE → IDLE after one clock.
- Address arithmetic is unsigned and computed in ADDRESS bits; it cannot overflow because the maximum address is 2·DIM²−1.
- start_seq is ignored outside IDLE.
- stall_seq does not stop the delay line: in-flight results still flag during a stall.
- Reset values: all addresses 0, ena_seq/clr_seq/flag_seq/busy_seq/done_seq 0, row_seq/col_seq 0, state IDLE, delay line empty.
- Reset asserted mid-operation aborts immediately with the reset values above. No flag is produced for partial dot products.

## Timing
- With DIV = 1, the first issue occurs in the clock after start acceptance. An issue with DIV = 1 occurs every clock unless stalled.
- Addresses are stable from their ena_seq pulse until the next issue.
- flag_seq is asserted exactly LAT clocks after the ena_seq of the j == DIM-1 issue.
- Total run length with no stall: DIM³·DIV clocks of issue, plus LAT clocks of drain, plus 1 clock for DONE.
- busy_seq rises in the clock after start_seq is sampled and falls with done_seq.

## Configuration
- MATMUL_SEQ_BROW_EN:
  - Defined: B is stored row-major. k = j·DIM + h.
  - Undefined: B is stored column-major. k = h·DIM + j.
- All other behaviour is identical in both builds.

## Structure
- Shared package matmul_pkg holds:
  - the FSM state enum
  - an address-calc function (i, h, j → four addresses), shared with the scoreboard
  - the default DIM/NBIT constants
- One sub-module, matmul_seq_dly: a parameterised LAT-deep valid+index delay line with asynchronous active-low clear.

## Test plan
- DIM=4, DIV=1, LAT=3; start → first issue: ar=0, ai=1, br=0, bi=1, clr_seq=1. 64 ena pulses; done_seq at clock 64+3+1.
- Same config, issue (i=1, h=0, j=2) → ar=12, ai=13, br=4, bi=5. Issue (0, 1, 0) → br=8 (MATMUL_SEQ_BROW_EN undefined); br=2 (defined).
- Flag order: 16 flag_seq pulses with (row, col) = (0,0), (0,1) … (3,3); each pulse is 3 clocks after its j=3 ena.
- DIV=4, stall_seq high for 10 clocks mid-row → no ena_seq during the stall. A pending flag still fires. Addresses resume with no skipped or repeated index; total time grows by 10.
- rst_seq low during RUN, then start again → all outputs return to 0, no further flag_seq, and the next run starts at address 0.
- start_seq pulsed while busy_seq is high → ignored; the issue count stays 64.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the complex matrix-multiply sequencer: FSM state encoding,
// default sizes and the (i, h, j) -> memory address map. MATMUL_SEQ_BROW_EN selects row-major B.
package matmul_pkg;

  localparam int unsigned DefDim  = 32;
  localparam int unsigned DefNbit = 32;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t StIdle  = 2'd0;
  localparam seq_state_t StRun   = 2'd1;
  localparam seq_state_t StDrain = 2'd2;
  localparam seq_state_t StDone  = 2'd3;

  typedef struct packed {
    logic [31:0] ar;
    logic [31:0] ai;
    logic [31:0] br;
    logic [31:0] bi;
  } addr_set_t;

  // Real and imaginary parts are interleaved, so each element occupies two words.
  function automatic addr_set_t calc_addr(input int unsigned dim, input int unsigned i,
                                          input int unsigned h, input int unsigned j);
    addr_set_t   a;
    int unsigned k;
`ifdef MATMUL_SEQ_BROW_EN
    k = j * dim + h;
`else
    k = h * dim + j;
`endif
    a.ar = 2 * j + 2 * dim * i;
    a.ai = a.ar + 1;
    a.br = 2 * k;
    a.bi = a.br + 1;
    return a;
  endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Control/address bundle between the matmul sequencer (master) and the memories,
// accumulator and host (slave).
interface matmul_seq_if #(
  parameter int unsigned DIM     = matmul_pkg::DefDim,
  parameter int unsigned ADDRESS = $clog2(2 * DIM * DIM)
);
  localparam int unsigned IdxW = $clog2(DIM);

  logic               start_seq;
  logic               stall_seq;
  logic [ADDRESS-1:0] addr_ar_seq;
  logic [ADDRESS-1:0] addr_ai_seq;
  logic [ADDRESS-1:0] addr_br_seq;
  logic [ADDRESS-1:0] addr_bi_seq;
  logic               ena_seq;
  logic               clr_seq;
  logic               flag_seq;
  logic [IdxW-1:0]    row_seq;
  logic [IdxW-1:0]    col_seq;
  logic               busy_seq;
  logic               done_seq;

  modport master (
    input  start_seq, stall_seq,
    output addr_ar_seq, addr_ai_seq, addr_br_seq, addr_bi_seq,
    output ena_seq, clr_seq, flag_seq, row_seq, col_seq, busy_seq, done_seq
  );

  modport slave (
    output start_seq, stall_seq,
    input  addr_ar_seq, addr_ai_seq, addr_br_seq, addr_bi_seq,
    input  ena_seq, clr_seq, flag_seq, row_seq, col_seq, busy_seq, done_seq
  );
endinterface

// File: rtl/matmul_seq_dly.sv
// Lat-deep valid + (row, col) shift line that tracks dot products through the accumulator.
module matmul_seq_dly #(
  parameter int unsigned Lat  = 3,
  parameter int unsigned IdxW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            vld_i,
  input  logic [IdxW-1:0] row_i,
  input  logic [IdxW-1:0] col_i,
  output logic            vld_o,
  output logic [IdxW-1:0] row_o,
  output logic [IdxW-1:0] col_o,
  output logic            pend_o
);
  logic [Lat-1:0]           vld_q, vld_d;
  logic [Lat-1:0][IdxW-1:0] row_q, row_d;
  logic [Lat-1:0][IdxW-1:0] col_q, col_d;
  logic [Lat-1:0]           early;

  always_comb begin
    vld_d    = vld_q;
    row_d    = row_q;
    col_d    = col_q;
    vld_d[0] = vld_i;
    row_d[0] = row_i;
    col_d[0] = col_i;
    for (int unsigned s = 1; s < Lat; s++) begin
      vld_d[s] = vld_q[s-1];
      row_d[s] = row_q[s-1];
      col_d[s] = col_q[s-1];
    end
  end

  // Pending excludes the entry currently being flagged so the drain ends with the last flag.
  always_comb begin
    early          = vld_q;
    early[Lat-1]   = 1'b0;
    pend_o         = vld_i | (|early);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      vld_q <= vld_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign vld_o = vld_q[Lat-1];
  assign row_o = row_q[Lat-1];
  assign col_o = col_q[Lat-1];
endmodule

// File: rtl/matmul_seq.sv
// Address/control sequencer for C = A*B: walks i, h, j and issues interleaved re/im addresses.
// Build option MATMUL_SEQ_BROW_EN switches B addressing from column-major to row-major.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned NBIT    = DefNbit,
  parameter int unsigned DIM     = DefDim,
  parameter int unsigned ADDRESS = $clog2(2 * DIM * DIM),
  parameter int unsigned DIV     = 16,
  parameter int unsigned LAT     = 3
) (
  input logic          clk_seq,
  input logic          rst_seq,
  matmul_seq_if.master bus
);
  localparam int unsigned     IdxW   = $clog2(DIM);
  localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIM - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  if (NBIT < 1 || DIV < 1 || LAT < 1 || ADDRESS < $clog2(2 * DIM * DIM)) begin : g_param_err
    $error("matmul_seq: illegal parameter combination");
  end

  seq_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    i_q, i_d, h_q, h_d, j_q, j_d;
  logic [ADDRESS-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic               ena_q, ena_d, clr_q, clr_d;
  logic               push_q, push_d;
  logic [IdxW-1:0]    push_row_q, push_row_d, push_col_q, push_col_d;
  logic               issue, last_i, last_h, last_j, pend;
  addr_set_t          a;
  logic               unused_addr_hi;

  assign a      = calc_addr(DIM, 32'(i_q), 32'(h_q), 32'(j_q));
  assign last_i = (i_q == IdxMax);
  assign last_h = (h_q == IdxMax);
  assign last_j = (j_q == IdxMax);
  assign issue  = (state_q == StRun) && !bus.stall_seq && (cnt_q == CntMax);

  // Addresses never exceed 2*DIM^2-1, so the upper word bits are always zero.
  assign unused_addr_hi = ^{a.ar[31:ADDRESS], a.ai[31:ADDRESS], a.br[31:ADDRESS],
                            a.bi[31:ADDRESS]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_d        = i_q;
    h_d        = h_q;
    j_d        = j_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    br_d       = br_q;
    bi_d       = bi_q;
    ena_d      = 1'b0;
    clr_d      = 1'b0;
    push_d     = 1'b0;
    push_row_d = push_row_q;
    push_col_d = push_col_q;

    case (state_q)
      StIdle: begin
        if (bus.start_seq) begin
          state_d = StRun;
          cnt_d   = '0;
          i_d     = '0;
          h_d     = '0;
          j_d     = '0;
        end
      end
      StRun: begin
        if (!bus.stall_seq) begin
          cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
        if (issue) begin
          ar_d       = ADDRESS'(a.ar);
          ai_d       = ADDRESS'(a.ai);
          br_d       = ADDRESS'(a.br);
          bi_d       = ADDRESS'(a.bi);
          ena_d      = 1'b1;
          clr_d      = (j_q == '0);
          push_d     = last_j;
          push_row_d = i_q;
          push_col_d = h_q;
          if (last_j) begin
            j_d = '0;
            if (last_h) begin
              h_d = '0;
              i_d = last_i ? '0 : i_q + IdxW'(1);
            end else begin
              h_d = h_q + IdxW'(1);
            end
          end else begin
            j_d = j_q + IdxW'(1);
          end
          if (last_i && last_h && last_j) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!pend) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_seq or negedge rst_seq) begin
    if (!rst_seq) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      i_q        <= '0;
      h_q        <= '0;
      j_q        <= '0;
      ar_q       <= '0;
      ai_q       <= '0;
      br_q       <= '0;
      bi_q       <= '0;
      ena_q      <= 1'b0;
      clr_q      <= 1'b0;
      push_q     <= 1'b0;
      push_row_q <= '0;
      push_col_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      h_q        <= h_d;
      j_q        <= j_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      br_q       <= br_d;
      bi_q       <= bi_d;
      ena_q      <= ena_d;
      clr_q      <= clr_d;
      push_q     <= push_d;
      push_row_q <= push_row_d;
      push_col_q <= push_col_d;
    end
  end

  // push_q already lags the issue edge by one clock, so LAT stages land the flag LAT after ena.
  matmul_seq_dly #(
    .Lat  (LAT),
    .IdxW (IdxW)
  ) u_dly (
    .clk_i  (clk_seq),
    .rst_ni (rst_seq),
    .vld_i  (push_q),
    .row_i  (push_row_q),
    .col_i  (push_col_q),
    .vld_o  (bus.flag_seq),
    .row_o  (bus.row_seq),
    .col_o  (bus.col_seq),
    .pend_o (pend)
  );

  assign bus.addr_ar_seq = ar_q;
  assign bus.addr_ai_seq = ai_q;
  assign bus.addr_br_seq = br_q;
  assign bus.addr_bi_seq = bi_q;
  assign bus.ena_seq     = ena_q;
  assign bus.clr_seq     = clr_q;
  assign bus.busy_seq    = (state_q == StRun) || (state_q == StDrain);
  assign bus.done_seq    = (state_q == StDone);
endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: DIM=4, LAT=3 with DIV=1 and DIV=4 instances,
// random stalls, spurious starts and mid-run resets against an index-order reference model.
module tb_matmul_seq;
  localparam int unsigned Dim    = 4;
  localparam int unsigned Lat    = 3;
  localparam int unsigned Addr   = 5;
  localparam int unsigned IdxW   = 2;
  localparam int          NIssue = Dim * Dim * Dim;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul_seq_if #(.DIM(Dim), .ADDRESS(Addr)) bus1 ();
  matmul_seq_if #(.DIM(Dim), .ADDRESS(Addr)) bus4 ();

  matmul_seq #(.NBIT(32), .DIM(Dim), .ADDRESS(Addr), .DIV(1), .LAT(Lat)) dut1 (
    .clk_seq (clk),
    .rst_seq (rst_n),
    .bus     (bus1)
  );

  matmul_seq #(.NBIT(32), .DIM(Dim), .ADDRESS(Addr), .DIV(4), .LAT(Lat)) dut4 (
    .clk_seq (clk),
    .rst_seq (rst_n),
    .bus     (bus4)
  );

  int checks = 0;
  int errors = 0;
  bit sel4   = 1'b0;

  logic [Addr-1:0] o_ar, o_ai, o_br, o_bi;
  logic            o_ena, o_clr, o_flag, o_busy, o_done;
  logic [IdxW-1:0] o_row, o_col;

  assign o_ar   = sel4 ? bus4.addr_ar_seq : bus1.addr_ar_seq;
  assign o_ai   = sel4 ? bus4.addr_ai_seq : bus1.addr_ai_seq;
  assign o_br   = sel4 ? bus4.addr_br_seq : bus1.addr_br_seq;
  assign o_bi   = sel4 ? bus4.addr_bi_seq : bus1.addr_bi_seq;
  assign o_ena  = sel4 ? bus4.ena_seq     : bus1.ena_seq;
  assign o_clr  = sel4 ? bus4.clr_seq     : bus1.clr_seq;
  assign o_flag = sel4 ? bus4.flag_seq    : bus1.flag_seq;
  assign o_busy = sel4 ? bus4.busy_seq    : bus1.busy_seq;
  assign o_done = sel4 ? bus4.done_seq    : bus1.done_seq;
  assign o_row  = sel4 ? bus4.row_seq     : bus1.row_seq;
  assign o_col  = sel4 ? bus4.col_seq     : bus1.col_seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit start, input bit stall);
    bus1.start_seq = !sel4 && start;
    bus1.stall_seq = !sel4 && stall;
    bus4.start_seq = sel4 && start;
    bus4.stall_seq = sel4 && stall;
  endtask

  // B element (j, h) storage index: column-major by default, row-major with the build option.
  function automatic int exp_br(input int h, input int j);
    int k;
`ifdef MATMUL_SEQ_BROW_EN
    k = j * Dim + h;
`else
    k = h * Dim + j;
`endif
    return 2 * k;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ar"}, o_ar, 0);
    check({tag, "_ai"}, o_ai, 0);
    check({tag, "_br"}, o_br, 0);
    check({tag, "_bi"}, o_bi, 0);
    check({tag, "_ena"}, o_ena, 0);
    check({tag, "_clr"}, o_clr, 0);
    check({tag, "_flag"}, o_flag, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_row"}, o_row, 0);
    check({tag, "_col"}, o_col, 0);
  endtask

  // One full computation; products are expected every DIV un-stalled clocks in (i, h, j) order.
  task automatic run(input bit d4, input int stall_at, input int stall_len, input bit rnd_stall,
                     input bit spur_start);
    int div, t, n_iss, active, stalls, last_t, done_t, bound, ii, hh, jj;
    bit st, exp_ena, exp_flag, fin;
    int fq_t[$];
    int fq_r[$];
    int fq_c[$];
    div    = d4 ? 4 : 1;
    bound  = div * NIssue * 3 + 64;
    sel4   = d4;
    t      = 0;
    n_iss  = 0;
    active = 0;
    stalls = 0;
    last_t = -1000;
    done_t = -1;
    fin    = 1'b0;
    drive(1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0);
    check("busy_rise", o_busy, 1);
    check("ena_at_accept", o_ena, 0);
    while (!fin && t < bound) begin
      st = ((t + 1 >= stall_at) && (t + 1 < stall_at + stall_len)) ||
           (rnd_stall && $urandom_range(0, 3) == 0);
      drive(spur_start && n_iss < NIssue && $urandom_range(0, 7) == 0, st);
      @(negedge clk);
      t++;
      exp_ena = 1'b0;
      if (n_iss < NIssue) begin
        if (st) stalls++;
        else begin
          active++;
          exp_ena = (active % div) == 0;
        end
      end
      check("ena", o_ena, exp_ena);
      if (o_ena === 1'b1 && n_iss < NIssue) begin
        ii = n_iss / (Dim * Dim);
        hh = (n_iss / Dim) % Dim;
        jj = n_iss % Dim;
        check("addr_ar", o_ar, 2 * jj + 2 * Dim * ii);
        check("addr_ai", o_ai, 2 * jj + 2 * Dim * ii + 1);
        check("addr_br", o_br, exp_br(hh, jj));
        check("addr_bi", o_bi, exp_br(hh, jj) + 1);
        check("clr", o_clr, jj == 0);
        if (jj == Dim - 1) begin
          fq_t.push_back(t + Lat);
          fq_r.push_back(ii);
          fq_c.push_back(hh);
        end
        n_iss++;
        if (n_iss == NIssue) last_t = t;
      end
      exp_flag = fq_t.size() > 0 && fq_t[0] == t;
      check("flag", o_flag, exp_flag);
      if (exp_flag) begin
        check("flag_row", o_row, fq_r[0]);
        check("flag_col", o_col, fq_c[0]);
        void'(fq_t.pop_front());
        void'(fq_r.pop_front());
        void'(fq_c.pop_front());
      end
      check("done", o_done, n_iss == NIssue && t == last_t + Lat + 1);
      check("busy", o_busy, !(n_iss == NIssue && t >= last_t + Lat + 1));
      if (o_done === 1'b1) done_t = t;
      fin = n_iss == NIssue && t >= last_t + Lat + 2;
    end
    drive(1'b0, 1'b0);
    check("run_timeout", fin, 1);
    check("issue_count", n_iss, NIssue);
    check("flags_missing", fq_t.size(), 0);
    check("run_length", done_t, div * NIssue + Lat + 1 + stalls);
  endtask

  // Start a run, reset it partway, and confirm nothing leaks out afterwards.
  task automatic abort_run(input bit d4, input int at);
    sel4 = d4;
    drive(1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0);
    repeat (at) @(negedge clk);
    check("abort_was_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_flag", o_flag, 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_abort_flag", o_flag, 0);
      check("post_abort_ena", o_ena, 0);
      check("post_abort_busy", o_busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel4 = d[0];
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 0, 0, 1'b0, 1'b0);
    run(1'b1, int'($urandom_range(20, 200)), 10, 1'b0, 1'b0);
    run(1'b0, 0, 0, 1'b1, 1'b1);
    abort_run(1'b0, 30);
    run(1'b0, 0, 0, 1'b0, 1'b0);
    abort_run(1'b1, int'($urandom_range(20, 200)));
    run(1'b1, 0, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
